// File: rtl/aibnd_dly_pkg.sv
// Shared width defaults, step-direction type and Gray conversion helpers
// for the delay-line code controller.
package aibnd_dly_pkg;

  localparam int DEF_COARSE_W = 7;
  localparam int DEF_FINE_W   = 3;
  localparam int DEF_STEP_DIV = 4;
  localparam int GRAY_MAX_W   = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } step_dir_e;

  // Callers zero-extend narrower codes; the upper Gray bits then stay zero.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/aibnd_dly_sync2.sv
// Two-flop synchroniser for asynchronous control inputs, one chain per bit,
// cleared by a synchronous active-high reset.
module aibnd_dly_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/aibnd_dly_code_ctrl.sv
// Ramps a {coarse,fine} delay code one LSB at a time toward a strobed target
// and drives Gray-coded outputs. Scan chain compiled in with AIBND_DLY_CODE_SCAN_EN.
module aibnd_dly_code_ctrl
  import aibnd_dly_pkg::*;
#(
  parameter int COARSE_W   = DEF_COARSE_W,
  parameter int FINE_W     = DEF_FINE_W,
  parameter int MAX_COARSE = 2**COARSE_W - 1,
  parameter int STEP_DIV   = DEF_STEP_DIV
) (
  input  logic                ck,
  input  logic                dll_reset,
  input  logic                code_valid,
  input  logic [COARSE_W-1:0] c_bin,
  input  logic [FINE_W-1:0]   f_bin,
  input  logic                se_n,
  input  logic                si,
  output logic [COARSE_W-1:0] c_gray,
  output logic [FINE_W-1:0]   f_gray,
  output logic                busy,
  output logic                done,
  output logic                clamped,
  output logic                so
);

  localparam int                  N        = COARSE_W + FINE_W;
  localparam logic [N-1:0]        CODE_ONE = N'(1);
  localparam logic [COARSE_W-1:0] MAX_C    = COARSE_W'(MAX_COARSE);
  localparam logic [7:0]          DIV_LAST = 8'(STEP_DIV - 1);

  logic [N-1:0]        tgt_reg, tgt_next;
  logic [N-1:0]        cur_reg, cur_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic                clamped_reg, clamped_next;
  logic                done_reg, done_next;
  logic                vld_prev_reg;
  logic [COARSE_W-1:0] c_gray_reg, c_gray_next;
  logic [FINE_W-1:0]   f_gray_reg, f_gray_next;

  logic      vld_sync;
  logic      load_evt;
  logic      step_evt;
  logic      scan_shift;
  logic      busy_int;
  step_dir_e dir;

  aibnd_dly_sync2 #(
    .WIDTH (1)
  ) u_sync (
    .clk  (ck),
    .srst (dll_reset),
    .d    (code_valid),
    .q    (vld_sync)
  );

`ifdef AIBND_DLY_CODE_SCAN_EN
  assign scan_shift = ~se_n;
  assign so         = cur_reg[N-1];
`else
  logic unused_scan;
  assign unused_scan = se_n;
  assign scan_shift  = 1'b0;
  assign so          = 1'b0;
`endif

  always_comb begin
    dir = DIR_HOLD;
    if (cur_reg < tgt_reg) begin
      dir = DIR_UP;
    end else if (cur_reg > tgt_reg) begin
      dir = DIR_DOWN;
    end
  end

  assign busy_int = (dir != DIR_HOLD);
  assign load_evt = vld_sync & ~vld_prev_reg & ~scan_shift;
  // A load on a step boundary wins: the counter restarts instead of stepping.
  assign step_evt = busy_int & ~scan_shift & ~load_evt & (cnt_reg == DIV_LAST);

  always_comb begin
    tgt_next     = tgt_reg;
    cur_next     = cur_reg;
    cnt_next     = cnt_reg;
    clamped_next = clamped_reg;

    if (scan_shift) begin
      tgt_next = {tgt_reg[N-2:0], si};
      cur_next = {cur_reg[N-2:0], tgt_reg[N-1]};
      cnt_next = '0;
    end else if (load_evt) begin
      cnt_next = '0;
      if (c_bin > MAX_C) begin
        tgt_next     = {MAX_C, {FINE_W{1'b1}}};
        clamped_next = 1'b1;
      end else begin
        tgt_next = {c_bin, f_bin};
      end
    end else if (step_evt) begin
      cnt_next = '0;
      cur_next = (dir == DIR_UP) ? cur_reg + CODE_ONE : cur_reg - CODE_ONE;
    end else if (busy_int) begin
      cnt_next = cnt_reg + 8'd1;
    end else begin
      cnt_next = '0;
    end

    // Covers both the final step and a load that already matches the code.
    done_next = ~scan_shift & (busy_int | load_evt) & (cur_next == tgt_next);

    c_gray_next = COARSE_W'(bin2gray(GRAY_MAX_W'(cur_next[N-1:FINE_W])));
    f_gray_next = FINE_W'(bin2gray(GRAY_MAX_W'(cur_next[FINE_W-1:0])));
  end

  always_ff @(posedge ck) begin
    if (dll_reset) begin
      vld_prev_reg <= 1'b0;
      tgt_reg      <= '0;
      cur_reg      <= '0;
      cnt_reg      <= '0;
      clamped_reg  <= 1'b0;
      done_reg     <= 1'b0;
      c_gray_reg   <= '0;
      f_gray_reg   <= '0;
    end else begin
      vld_prev_reg <= vld_sync;
      tgt_reg      <= tgt_next;
      cur_reg      <= cur_next;
      cnt_reg      <= cnt_next;
      clamped_reg  <= clamped_next;
      done_reg     <= done_next;
      c_gray_reg   <= c_gray_next;
      f_gray_reg   <= f_gray_next;
    end
  end

  assign c_gray  = c_gray_reg;
  assign f_gray  = f_gray_reg;
  assign busy    = busy_int;
  assign done    = done_reg;
  assign clamped = clamped_reg;

endmodule

// File: tb/tb_aibnd_dly_code_ctrl.sv
// Randomised bench for aibnd_dly_code_ctrl against a closed-form ramp model;
// the scan scenario follows AIBND_DLY_CODE_SCAN_EN.
module tb_aibnd_dly_code_ctrl;

  localparam int CW   = 7;
  localparam int FW   = 3;
  localparam int NW   = CW + FW;
  localparam int MAXC = 100;
  localparam int SD   = 4;

  logic          ck = 1'b0;
  logic          dll_reset = 1'b1;
  logic          code_valid = 1'b0;
  logic [CW-1:0] c_bin = '0;
  logic [FW-1:0] f_bin = '0;
  logic          se_n = 1'b1;
  logic          si = 1'b0;
  logic [CW-1:0] c_gray;
  logic [FW-1:0] f_gray;
  logic          busy, done, clamped, so;

  int checks = 0;
  int errors = 0;
  int cur_m = 0;
  int tgt_m = 0;
  bit clamped_m = 1'b0;

  always #5 ck = ~ck;

  aibnd_dly_code_ctrl #(
    .COARSE_W   (CW),
    .FINE_W     (FW),
    .MAX_COARSE (MAXC),
    .STEP_DIV   (SD)
  ) dut (
    .ck         (ck),
    .dll_reset  (dll_reset),
    .code_valid (code_valid),
    .c_bin      (c_bin),
    .f_bin      (f_bin),
    .se_n       (se_n),
    .si         (si),
    .c_gray     (c_gray),
    .f_gray     (f_gray),
    .busy       (busy),
    .done       (done),
    .clamped    (clamped),
    .so         (so)
  );

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  // Strobe a target; returns just after the edge that loads it.
  task automatic do_load(input int c, input int f);
    @(posedge ck);
    #1;
    c_bin = CW'(c);
    f_bin = FW'(f);
    code_valid = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    code_valid = 1'b0;
    if (c > MAXC) begin
      tgt_m = MAXC * (1 << FW) + (1 << FW) - 1;
      clamped_m = 1'b1;
    end else begin
      tgt_m = c * (1 << FW) + f;
    end
    $display("load c_bin=%0d f_bin=%0d -> target %0d from %0d", c, f, tgt_m, cur_m);
  endtask

  // Cycle c after a load: code has moved floor(c/SD) steps (capped at the distance).
  task automatic track(input int start, input int tgt, input int ncyc, input bit loaded, input string tag);
    int d, dir, steps, expv, so_exp;
    logic [CW-1:0] pc;
    logic [FW-1:0] pf;
    d    = (tgt > start) ? tgt - start : start - tgt;
    dir  = (tgt >= start) ? 1 : -1;
    expv = start;
    pc   = c_gray;
    pf   = f_gray;
    for (int c = 0; c < ncyc; c++) begin
      if (!se_n) si = 1'($urandom);
      @(negedge ck);
      steps = c / SD;
      if (steps > d) steps = d;
      expv = start + dir * steps;
`ifdef AIBND_DLY_CODE_SCAN_EN
      so_exp = (expv >> (NW - 1)) & 1;
`else
      so_exp = 0;
`endif
      checks++;
      if (c_gray !== CW'(gray(expv >> FW)) || f_gray !== FW'(gray(expv & ((1 << FW) - 1)))) begin
        errors++;
        $display("FAIL %s code cyc=%0d got c_gray=%0d f_gray=%0d expected c_gray=%0d f_gray=%0d",
                 tag, c, c_gray, f_gray, gray(expv >> FW), gray(expv & ((1 << FW) - 1)));
      end
      checks++;
      if (busy !== (steps < d)) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got %0b expected %0b", tag, c, busy, steps < d);
      end
      checks++;
      if (done !== (loaded && c == d * SD)) begin
        errors++;
        $display("FAIL %s done cyc=%0d got %0b expected %0b", tag, c, done, loaded && c == d * SD);
      end
      checks++;
      if ($countones(c_gray ^ pc) > 1 || $countones(f_gray ^ pf) > 1) begin
        errors++;
        $display("FAIL %s toggle cyc=%0d c_gray %0d->%0d f_gray %0d->%0d expected at most one bit each",
                 tag, c, pc, c_gray, pf, f_gray);
      end
      checks++;
      if (so !== 1'(so_exp)) begin
        errors++;
        $display("FAIL %s so cyc=%0d got %0b expected %0d", tag, c, so, so_exp);
      end
      pc = c_gray;
      pf = f_gray;
    end
    cur_m = expv;
    checks++;
    if (clamped !== clamped_m) begin
      errors++;
      $display("FAIL %s clamped got %0b expected %0b", tag, clamped, clamped_m);
    end
    $display("track %s start=%0d target=%0d cycles=%0d code=%0d", tag, start, tgt, ncyc, cur_m);
  endtask

  task automatic test_reset();
    dll_reset = 1'b1;
    repeat (3) @(negedge ck);
    checks++;
    if ({c_gray, f_gray} !== '0) begin
      errors++;
      $display("FAIL reset_code got c_gray=%0d f_gray=%0d expected 0 0", c_gray, f_gray);
    end
    checks++;
    if ({busy, done, clamped, so} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got busy/done/clamped/so=%b expected 0000", {busy, done, clamped, so});
    end
    dll_reset = 1'b0;
    cur_m = 0; tgt_m = 0; clamped_m = 1'b0;
    track(0, 0, 4, 1'b0, "reset_idle");
  endtask

  task automatic test_basic();
    @(posedge ck);
    #1;
    c_bin = 7'd3;
    f_bin = 3'd2;
    code_valid = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge ck);
      @(negedge ck);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_load edge=%0d busy got %0b expected 0", e, busy);
      end
    end
    @(posedge ck);
    #1;
    code_valid = 1'b0;
    tgt_m = 26;
    $display("load c_bin=3 f_bin=2 -> target 26 from 0");
    track(0, 26, 26 * SD + 2, 1'b1, "basic");
    checks++;
    if (c_gray !== 7'd2 || f_gray !== 3'd3) begin
      errors++;
      $display("FAIL basic_final got c_gray=%0d f_gray=%0d expected 2 3", c_gray, f_gray);
    end
  endtask

  task automatic test_carry();
    do_load(3, 7);
    track(26, 31, 5 * SD + 2, 1'b1, "carry_pre");
    checks++;
    if (c_gray !== 7'd2 || f_gray !== 3'd4) begin
      errors++;
      $display("FAIL carry_before got c_gray=%0d f_gray=%0d expected 2 4", c_gray, f_gray);
    end
    do_load(4, 0);
    track(31, 32, SD + 2, 1'b1, "carry");
    checks++;
    if (c_gray !== 7'd6 || f_gray !== 3'd0) begin
      errors++;
      $display("FAIL carry_after got c_gray=%0d f_gray=%0d expected 6 0", c_gray, f_gray);
    end
  endtask

  task automatic test_clamp();
    int start;
    start = cur_m;
    do_load(127, 0);
    track(start, tgt_m, (tgt_m - start) * SD + 2, 1'b1, "clamp");
    do_load(100, 7);
    track(cur_m, tgt_m, 3, 1'b1, "clamp_equal");
    checks++;
    if (clamped !== 1'b1) begin
      errors++;
      $display("FAIL clamp_sticky got %0b expected 1", clamped);
    end
  endtask

  task automatic test_abort();
    int start;
    start = cur_m;
    do_load(60, 0);
    track(start, tgt_m, 30, 1'b1, "abort_ramp");
    dll_reset = 1'b1;
    @(negedge ck);
    checks++;
    if ({c_gray, f_gray} !== '0) begin
      errors++;
      $display("FAIL abort_code got c_gray=%0d f_gray=%0d expected 0 0", c_gray, f_gray);
    end
    checks++;
    if ({busy, done, clamped, so} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_flags got busy/done/clamped/so=%b expected 0000", {busy, done, clamped, so});
    end
    dll_reset = 1'b0;
    cur_m = 0; tgt_m = 0; clamped_m = 1'b0;
    track(0, 0, 20, 1'b0, "abort_idle");
  endtask

  task automatic test_reverse();
    do_load(5, 0);
    track(0, 40, 79, 1'b1, "reverse_up");
    do_load(1, 2);
    cur_m = 82 / SD;
    track(cur_m, 10, (cur_m - 10) * SD + 2, 1'b1, "reverse_down");
  endtask

  task automatic test_random();
    int kind, c, f, start, d, dir, n;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        c = cur_m >> FW;
        f = cur_m & ((1 << FW) - 1);
      end else if (kind == 1) begin
        c = $urandom_range(MAXC + 1, (1 << CW) - 1);
        f = $urandom_range(0, (1 << FW) - 1);
      end else begin
        c = $urandom_range(0, MAXC);
        f = $urandom_range(0, (1 << FW) - 1);
      end
      start = cur_m;
      do_load(c, f);
      d   = (tgt_m > start) ? tgt_m - start : start - tgt_m;
      dir = (tgt_m >= start) ? 1 : -1;
      if (it < 9 && d >= 2 && $urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, d * SD - 1);
        if ((n + 3) % SD == 0) n++;
        track(start, tgt_m, n, 1'b1, "rand_partial");
        cur_m = start + dir * (((n + 2) / SD < d) ? (n + 2) / SD : d);
      end else begin
        track(start, tgt_m, d * SD + 2, 1'b1, "rand_full");
      end
    end
  endtask

`ifdef AIBND_DLY_CODE_SCAN_EN
  task automatic test_scan();
    logic [19:0] pat;
    int start, expc;
    pat = 20'($urandom);
    pat[19] = 1'b0;
    start = cur_m;
    do_load(50, 0);
    track(start, tgt_m, 10, 1'b1, "scan_pre");
    se_n = 1'b0;
    expc = 0;
    for (int k = 0; k < NW; k++) expc = expc + (int'(pat[k]) << (NW - 1 - k));
    for (int j = 0; j < 39; j++) begin
      si = (j < 20) ? pat[j] : 1'b0;
      @(negedge ck);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL scan_done shift=%0d got %0b expected 0", j, done);
      end
      if (j == 19) begin
        checks++;
        if (c_gray !== CW'(gray(expc >> FW)) || f_gray !== FW'(gray(expc & ((1 << FW) - 1)))) begin
          errors++;
          $display("FAIL scan_code got c_gray=%0d f_gray=%0d expected %0d %0d",
                   c_gray, f_gray, gray(expc >> FW), gray(expc & ((1 << FW) - 1)));
        end
      end
      if (j >= 19) begin
        checks++;
        if (so !== pat[j-19]) begin
          errors++;
          $display("FAIL scan_so bit=%0d got %0b expected %0b", j - 19, so, pat[j-19]);
        end
      end
    end
    se_n = 1'b1;
    si = 1'b0;
    $display("scan pattern=%05h shifted through 2x%0d bits", pat, NW);
    cur_m = 0; tgt_m = 0;
    track(0, 0, 6, 1'b0, "scan_post");
  endtask
`else
  task automatic test_scan();
    int start;
    start = cur_m;
    se_n = 1'b0;
    do_load($urandom_range(0, MAXC), $urandom_range(0, (1 << FW) - 1));
    track(start, tgt_m, ((tgt_m > start) ? tgt_m - start : start - tgt_m) * SD + 2, 1'b1, "scan_ignored");
    se_n = 1'b1;
    si = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_clamp();
    test_abort();
    test_reverse();
    test_random();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aibnd_dly_code_ctrl.md
AIBND_DLY_CODE_CTRL -- requirements
Module: aibnd_dly_code_ctrl

Interface
REQ-001 SHALL have parameter COARSE_W, default 7: coarse code width in bits.
REQ-002 SHALL have parameter FINE_W, default 3: fine code width in bits.
REQ-003 SHALL have parameter MAX_COARSE, default 2**COARSE_W-1: highest coarse code allowed.
REQ-004 SHALL have parameter STEP_DIV, default 4, legal range 1..255: cycles between code steps.
REQ-005 SHALL have port ck, input, 1 bit: the single clock.
REQ-006 SHALL have port dll_reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port code_valid, input, 1 bit: asynchronous strobe announcing a new target.
REQ-008 SHALL have port c_bin, input, COARSE_W bits: binary coarse target.
REQ-009 SHALL have port f_bin, input, FINE_W bits: binary fine target.
REQ-010 SHALL have port se_n, input, 1 bit: scan shift enable, active-low.
REQ-011 SHALL have port si, input, 1 bit: scan data in.
REQ-012 SHALL have port c_gray, output, COARSE_W bits: registered Gray coarse code to the delay line.
REQ-013 SHALL have port f_gray, output, FINE_W bits: registered Gray fine code to the delay line.
REQ-014 SHALL have port busy, output, 1 bit: current code differs from target.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when current code reaches target.
REQ-016 SHALL have port clamped, output, 1 bit: sticky flag, target was clipped.
REQ-017 SHALL have port so, output, 1 bit: scan data out.

Function
REQ-018 SHALL synchronise code_valid through a 2-flop synchroniser, then rising-edge detect it; the target {c_bin,f_bin} is loaded on the cycle after the detected edge (3 ck cycles after the input edge).
REQ-019 SHALL clip a loaded coarse value above MAX_COARSE to {MAX_COARSE, fine all-ones} and set clamped; clamped clears only on reset.
REQ-020 SHALL treat the current code as one unsigned number {coarse,fine} of COARSE_W+FINE_W bits; each step is +1 or -1.
- Fine carries into coarse (fine max +1 gives fine 0, coarse +1); fine borrows from coarse on the way down.
- The current code never wraps past 0 or past the clipped maximum.
REQ-021 SHALL step once every STEP_DIV cycles while busy; the step counter restarts on every target load, so the first step comes STEP_DIV cycles after the load.
REQ-022 SHALL choose the direction each step by comparing current with target; a new load while busy retargets at once and may reverse direction.
REQ-023 SHALL update c_gray/f_gray in the same cycle as the current-code register.
- Each output is registered bin-to-Gray of the next value, so at most one output bit toggles per step.
REQ-024 SHALL assert busy combinationally from the registers whenever current != target.
REQ-025 SHALL pulse done for exactly one cycle on the cycle busy falls.
REQ-026 SHALL, on a load equal to the current code, leave busy low and pulse done once, on the cycle after the load.

Reset
REQ-027 SHALL, on dll_reset high at a ck edge, clear synchroniser, target, current code, step counter, clamped and scan state to 0.
REQ-028 SHALL present after reset: c_gray=0, f_gray=0, busy=0, done=0, clamped=0, so=0.
REQ-029 SHALL give reset priority over scan, load and step in the same cycle.
REQ-030 SHALL abort any ramp on reset mid-operation with no further steps.

Configuration
REQ-031 SHALL compile in scan only when macro AIBND_DLY_CODE_SCAN_EN is defined.
REQ-032 SHALL, with scan compiled in, form one chain with se_n=0: si -> target register (MSB first) -> current register -> so; no load or step occurs while se_n=0.
REQ-033 SHALL, without AIBND_DLY_CODE_SCAN_EN, tie so to 0 and leave se_n and si unused.

Structure
REQ-034 SHALL take bin2gray/gray2bin functions and default width constants from package aibnd_dly_pkg.
REQ-035 SHALL instantiate one sub-module, aibnd_dly_sync2 (2-flop synchroniser with synchronous active-high reset).

Verification
REQ-036 SHALL cover: reset, then code_valid with c_bin=3, f_bin=2, STEP_DIV=4 -> target loads at cycle 3 -> 26 steps, 4 cycles apart -> final c_gray=2, f_gray=3; done pulses once.
REQ-037 SHALL cover: from code 0x1F (c=3, f=7) load 0x20 -> one step -> f_gray goes 4 to 0 and c_gray goes 2 to 6 in the same cycle, one bit each.
REQ-038 SHALL cover: MAX_COARSE=100, load c_bin=127 -> target {100,7}, clamped=1 until reset.
REQ-039 SHALL cover: while ramping up toward 40, at current 20 load target 10 -> direction reverses, busy stays high, final code 10, one done pulse.
REQ-040 SHALL cover: dll_reset asserted mid-ramp -> next cycle all outputs 0, no further steps.
REQ-041 SHALL cover, with AIBND_DLY_CODE_SCAN_EN: se_n=0, shift in a 20-bit pattern -> so returns it after 2*(COARSE_W+FINE_W) cycles and no steps occur.
